// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/clear controller.
// Holds the FSM state encodings, the BCD reading width and the 100 MHz debounce default.
package stopwatch_pkg;

  localparam int BCD_W = 8;
  localparam int DEBOUNCE_CYCLES_100MHZ = 1000000;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    state_t state;
    logic   start_level;
    logic   clear_level;
    logic   lap_level;
  } dbg_t;

  // A zero limit means auto-stop is off; otherwise plain BCD equality.
  function automatic logic is_stop(input logic [BCD_W-1:0] reading,
                                   input logic [BCD_W-1:0] stop_at);
    return (stop_at != '0) && (reading == stop_at);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Link between the controller and the BCD seconds Counter.
// counter_init/counter_enable are levels, acted on every clock they are high; time_reading is
// always valid; no valid/ready handshake and no back-pressure exist on this link.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic             counter_init;
  logic             counter_enable;
  logic [BCD_W-1:0] time_reading;

  modport master (output counter_init, output counter_enable, input time_reading);
  modport slave  (input counter_init, input counter_enable, output time_reading);

endinterface

// File: rtl/stopwatch_ctrl_debouncer.sv
// button_debouncer: 2-FF synchroniser plus a stability counter; emits the accepted level and
// a one-clock press pulse registered one clock after the level rises.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
  input  logic clk,
  input  logic init_regs_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      level_d   <= 1'b0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_1    <= btn_raw;
      sync_2    <= sync_1;
      level_d   <= btn_level;
      btn_press <= btn_level & ~level_d;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (sync_2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= sync_2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for the BCD seconds Counter with programmable auto-stop.
// Optional lap-freeze feature is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
  parameter logic [BCD_W-1:0] STOP_AT         = 8'h59
) (
  input  logic                  clk,
  input  logic                  init_regs_n,
  input  logic                  btn_start_stop,
  input  logic                  btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic                  btn_lap,
  output logic                  lap_frozen,
`endif
  stopwatch_ctrl_if.master      ctr,
  output logic [BCD_W-1:0]      display_value,
  output logic                  running,
  output logic                  done,
  output dbg_t                  dbg
);

  state_t state;
  state_t nxt;
  logic   start_level, start_press;
  logic   clear_level, clear_press;
  logic   lap_level;
  logic   stop_hit;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .init_regs_n(init_regs_n), .btn_raw(btn_start_stop),
    .btn_level(start_level), .btn_press(start_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .init_regs_n(init_regs_n), .btn_raw(btn_clear),
    .btn_level(clear_level), .btn_press(clear_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_press;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .init_regs_n(init_regs_n), .btn_raw(btn_lap),
    .btn_level(lap_level), .btn_press(lap_press)
  );
`else
  assign lap_level = 1'b0;
`endif

  assign stop_hit = is_stop(ctr.time_reading, STOP_AT);
  assign dbg      = '{state: state, start_level: start_level,
                      clear_level: clear_level, lap_level: lap_level};

  // Clear beats the limit match, which beats start/stop.
  always_comb begin
    nxt = state;
    if (clear_press) begin
      nxt = ST_CLEAR;
    end else begin
      case (state)
        ST_CLEAR: nxt = ST_IDLE;
        ST_IDLE:  if (start_press) nxt = ST_RUN;
        ST_RUN: begin
          if (stop_hit)         nxt = ST_DONE;
          else if (start_press) nxt = ST_PAUSE;
        end
        ST_PAUSE: if (start_press) nxt = ST_RUN;
        ST_DONE:  nxt = ST_DONE;
        default:  nxt = ST_CLEAR;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      state              <= ST_CLEAR;
      ctr.counter_init   <= 1'b1;
      ctr.counter_enable <= 1'b0;
      running            <= 1'b0;
      done               <= 1'b0;
      display_value      <= '0;
`ifdef STOPWATCH_LAP_EN
      lap_frozen         <= 1'b0;
`endif
    end else begin
      state              <= nxt;
      ctr.counter_init   <= (nxt == ST_CLEAR);
      ctr.counter_enable <= (nxt == ST_RUN);
      running            <= (nxt == ST_RUN);
      done               <= (nxt == ST_DONE);
`ifdef STOPWATCH_LAP_EN
      if (!lap_frozen) display_value <= ctr.time_reading;
      if ((nxt == ST_CLEAR) || (nxt == ST_DONE)) begin
        lap_frozen <= 1'b0;
      end else if (lap_press && (state == ST_RUN)) begin
        lap_frozen <= ~lap_frozen;
      end else if (lap_press && (state == ST_PAUSE)) begin
        lap_frozen <= 1'b0;
      end
`else
      display_value <= ctr.time_reading;
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a behavioural Counter stand-in and an event-level reference model.
// Lap checks are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int         DC       = 4;
  localparam int         CLK_FREQ = 10;
  localparam logic [7:0] STOP     = 8'h05;
  localparam int M_CLEAR = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic [7:0] display_value;
  logic       running, done;
  dbg_t       dbg;
  logic       lap_raw;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap = 1'b0;
  logic       lap_frozen;
  assign lap_raw = btn_lap;
`else
  assign lap_raw = 1'b0;
`endif

  stopwatch_ctrl_if cif();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .STOP_AT(STOP)) dut (
    .clk(clk),
    .init_regs_n(rst_n),
    .btn_start_stop(btn_ss),
    .btn_clear(btn_clr),
`ifdef STOPWATCH_LAP_EN
    .btn_lap(btn_lap),
    .lap_frozen(lap_frozen),
`endif
    .ctr(cif.master),
    .display_value(display_value),
    .running(running),
    .done(done),
    .dbg(dbg)
  );

  // ---------------- Counter stand-in: BCD seconds, one tick per CLK_FREQ enabled clocks ----------------
  logic [7:0] reading;
  int         presc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t, o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  always @(posedge clk) begin
    if (cif.counter_init) begin
      reading <= 8'h00;
      presc   <= 0;
    end else if (cif.counter_enable) begin
      if (presc == CLK_FREQ - 1) begin
        presc   <= 0;
        reading <= bcd_inc(reading);
      end else begin
        presc <= presc + 1;
      end
    end
  end
  assign cif.time_reading = reading;

  // ---------------- scoreboard counters and check tasks ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_st(input string name, input state_t act, input state_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s at %0t", name, act.name(), exp.name(), $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button level is accepted once the last DC synchronised samples all differ from it;
  // the synchroniser makes the sample seen at edge e the raw value from edge e-2.
  int             m_mode;
  logic           m_lap;
  logic [7:0]     m_disp;
  logic [2:0]     m_lvl, m_pend, m_pulse;
  logic [DC+1:0]  m_hist [3];

  always @(posedge clk or negedge rst_n) begin
    int   nm;
    logic nlap;
    logic flip;
    logic [2:0] raw;
    if (!rst_n) begin
      m_mode  = M_CLEAR;
      m_lap   = 1'b0;
      m_disp  = 8'h00;
      m_lvl   = '0;
      m_pend  = '0;
      m_pulse = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
    end else begin
      nm = m_mode;
      if (m_pulse[1]) nm = M_CLEAR;
      else if (m_mode == M_CLEAR) nm = M_IDLE;
      else if (m_mode == M_RUN && STOP != 8'h00 && reading == STOP) nm = M_DONE;
      else if (m_pulse[0] && (m_mode == M_IDLE || m_mode == M_PAUSE)) nm = M_RUN;
      else if (m_pulse[0] && m_mode == M_RUN) nm = M_PAUSE;

      nlap = m_lap;
      if (nm == M_CLEAR || nm == M_DONE) nlap = 1'b0;
      else if (m_pulse[2] && m_mode == M_RUN) nlap = ~m_lap;
      else if (m_pulse[2] && m_mode == M_PAUSE) nlap = 1'b0;

      m_disp = m_lap ? m_disp : reading;
      m_lap  = nlap;
      m_mode = nm;

      raw = {lap_raw, btn_clr, btn_ss};
      m_pulse = m_pend;
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][DC:0], raw[b]};
        flip = (m_hist[b][DC+1:2] == {DC{~m_lvl[b]}});
        m_pend[b] = flip && !m_lvl[b];
        if (flip) m_lvl[b] = ~m_lvl[b];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk1("cmp_init",    cif.counter_init,   m_mode == M_CLEAR);
    chk1("cmp_enable",  cif.counter_enable, m_mode == M_RUN);
    chk1("cmp_running", running,            m_mode == M_RUN);
    chk1("cmp_done",    done,               m_mode == M_DONE);
    chk8("cmp_display", display_value,      m_disp);
`ifdef STOPWATCH_LAP_EN
    chk1("cmp_lap",     lap_frozen,         m_lap);
`endif
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic press(input logic ss, input logic clr, input logic lap, input int hold);
    btn_ss  = ss;
    btn_clr = clr;
`ifdef STOPWATCH_LAP_EN
    btn_lap = lap;
`else
    if (lap) $display("note: lap press skipped in this build");
`endif
    repeat (hold) @(negedge clk);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0;
`endif
    repeat (DC + 6) @(negedge clk);
  endtask

  task automatic count_init(input int cycles, output int n);
    n = 0;
    #1;
    if (cif.counter_init) n++;
    repeat (cycles) begin
      @(negedge clk);
      if (cif.counter_init) n++;
    end
  endtask

  task automatic wait_reading(input logic [7:0] v, input int budget);
    int k = 0;
    while (reading !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk8("wait_reading", reading, v);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset_init", cif.counter_init, 1'b1);
    chk1("reset_enable", cif.counter_enable, 1'b0);
    chk8("reset_display", display_value, 8'h00);
    chk1("reset_done", done, 1'b0);
    chk_st("reset_state", dbg.state, ST_CLEAR);

    rst_n = 1'b1;
    count_init(5, n);
    chki("init_pulse_after_reset", n, 1);
    chk_st("idle_after_reset", dbg.state, ST_IDLE);

    // 3-cycle glitch must not be accepted
    btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    chk_st("glitch_ignored", dbg.state, ST_IDLE);

    // clean start: enable rises 8 clocks after the raw edge
    btn_ss = 1'b1;
    n = 0;
    while (n < 20 && !cif.counter_enable) begin
      @(posedge clk);
      #1;
      n++;
    end
    chki("start_latency", n, 8);
    @(negedge clk);
    btn_ss = 1'b0;
    repeat (DC + 6) @(negedge clk);

    wait_reading(8'h03, 200);
    press(1'b1, 1'b0, 1'b0, 10);
    repeat (30) @(negedge clk);
    chk_st("pause_state", dbg.state, ST_PAUSE);
    chk8("pause_display", display_value, 8'h03);
    chk1("pause_enable", cif.counter_enable, 1'b0);

    press(1'b1, 1'b0, 1'b0, 10);
    wait_reading(8'h05, 200);
    repeat (30) @(negedge clk);
    chk_st("done_state", dbg.state, ST_DONE);
    chk1("done_flag", done, 1'b1);
    chk8("done_display", display_value, 8'h05);
    press(1'b1, 1'b0, 1'b0, 10);
    chk_st("done_ignores_start", dbg.state, ST_DONE);

    // clear held for 1000 cycles: a single init pulse
    btn_clr = 1'b1;
    count_init(1000, n);
    chki("held_clear_single_pulse", n, 1);
    btn_clr = 1'b0;
    repeat (DC + 6) @(negedge clk);
    chk_st("held_clear_idle", dbg.state, ST_IDLE);
    chk8("held_clear_display", display_value, 8'h00);

    // clear and start_stop in the same cycle while running
    press(1'b1, 1'b0, 1'b0, 10);
    wait_reading(8'h02, 200);
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    count_init(20, n);
    chki("clear_vs_start_pulse", n, 1);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (DC + 6) @(negedge clk);
    chk_st("clear_vs_start_idle", dbg.state, ST_IDLE);
    chk8("clear_vs_start_display", display_value, 8'h00);

    press(1'b1, 1'b0, 1'b0, 10);
`ifdef STOPWATCH_LAP_EN
    wait_reading(8'h02, 200);
    press(1'b0, 1'b0, 1'b1, 10);
    wait_reading(8'h04, 200);
    @(negedge clk);
    chk8("lap_display_frozen", display_value, 8'h02);
    chk1("lap_frozen_flag", lap_frozen, 1'b1);
    chk1("lap_enable_kept", cif.counter_enable, 1'b1);
`else
    wait_reading(8'h01, 200);
`endif

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrun_reset_init", cif.counter_init, 1'b1);
    chk1("midrun_reset_enable", cif.counter_enable, 1'b0);
    chk1("midrun_reset_running", running, 1'b0);
    chk8("midrun_reset_display", display_value, 8'h00);
    chk_st("midrun_reset_state", dbg.state, ST_CLEAR);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_init(5, n);
    chki("midrun_reset_init_pulse", n, 1);
    chk_st("midrun_reset_idle", dbg.state, ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
